// File: rtl/ram_responder.sv
//==============================================================================
// Module      : ram_responder
// Description : Word-addressed RAM model that answers a level-held request
//               handshake. A request is {ramaddr, ramREN, ramWEN}; while it is
//               held stable the responder reports BUSY for LAT cycles and then
//               ACCESS for one cycle, during which read data is presented or
//               write data is committed. Changing the request aborts and
//               restarts the access. An illegal request (both enables or a
//               misaligned address) reports ERROR.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   LAT       BUSY cycles before ACCESS (0..15)
//   DEPTH_W   log2 of storage depth in 32-bit words
// Ports
//   CLK       in   1   clock, rising edge
//   nRST      in   1   asynchronous active-low reset (also clears storage)
//   ramaddr   in   32  byte address of the request
//   ramREN    in   1   read request
//   ramWEN    in   1   write request
//   ramstore  in   32  write data, sampled at the commit edge
//   ramload   out  32  read data, zero unless ACCESS with ramREN
//   ramstate  out  2   0=FREE 1=BUSY 2=ACCESS 3=ERROR
//==============================================================================
`default_nettype none

module ram_responder #(
    parameter int LAT     = 2,
    parameter int DEPTH_W = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] ramaddr,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam logic [1:0] c_FREE   = 2'd0;
    localparam logic [1:0] c_BUSY   = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_ERROR  = 2'd3;

    localparam int         c_DEPTH    = 1 << DEPTH_W;
    // LAT==0 skips WAIT entirely, so the reload value is only meaningful
    // for LAT>=1; clamp it so the subtraction never wraps.
    localparam int         c_LAT_M1_I = (LAT > 0) ? LAT - 1 : 0;
    localparam logic [3:0] c_LAT_M1   = c_LAT_M1_I[3:0];
    localparam logic       c_LAT_ZERO = (LAT == 0);

    //--------------------------------------------------------------------------
    // State encoding
    //--------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [3:0]         r_cnt_q,   w_cnt_d;
    logic [31:0]        r_addr_q,  w_addr_d;
    logic               r_ren_q,   w_ren_d;
    logic               r_wen_q,   w_wen_d;

    logic [31:0]        r_mem_q [c_DEPTH];

    //--------------------------------------------------------------------------
    // Request classification
    //--------------------------------------------------------------------------
    logic               w_any;
    logic               w_err;
    logic               w_valid;
    logic               w_match;
    logic               w_access;
    logic [DEPTH_W-1:0] w_lat_idx;

    assign w_any   = ramREN | ramWEN;
    // A request with neither enable is "no request", never an error, even if
    // the address happens to be misaligned.
    assign w_err   = w_any & ((ramREN & ramWEN) | (ramaddr[1:0] != 2'b00));
    assign w_valid = w_any & ~w_err;

    // The full 32-bit address takes part in the comparison: aliased addresses
    // hit the same word but are still different requests.
    assign w_match = (ramaddr == r_addr_q) && (ramREN == r_ren_q) && (ramWEN == r_wen_q);

    // Upper address bits are dropped here, which is what makes storage alias.
    assign w_lat_idx = r_addr_q[DEPTH_W+1:2];

    assign w_access = (r_state_q == S_DONE) && w_match;

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        logic w_start;

        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_addr_d  = r_addr_q;
        w_ren_d   = r_ren_q;
        w_wen_d   = r_wen_q;
        w_start   = 1'b0;

        if (!w_any) begin
            w_state_d = S_IDLE;
        end else if (w_err) begin
            w_state_d = S_ERR;
        end else if (w_valid) begin
            case (r_state_q)
                S_WAIT: begin
                    if (w_match) begin
                        if (r_cnt_q == 4'd0) begin
                            w_state_d = S_DONE;
                        end else begin
                            w_cnt_d = r_cnt_q - 4'd1;
                        end
                    end else begin
                        // Request changed mid-wait: abandon and restart.
                        w_start = 1'b1;
                    end
                end
                // IDLE, ERR and DONE all (re)latch: DONE with the same
                // request starts the next back-to-back access, DONE with a
                // different one is an abort.
                default: w_start = 1'b1;
            endcase
        end

        if (w_start) begin
            w_addr_d  = ramaddr;
            w_ren_d   = ramREN;
            w_wen_d   = ramWEN;
            w_cnt_d   = c_LAT_M1;
            w_state_d = c_LAT_ZERO ? S_DONE : S_WAIT;
        end
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= 4'd0;
            r_addr_q  <= 32'h0;
            r_ren_q   <= 1'b0;
            r_wen_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_addr_q  <= w_addr_d;
            r_ren_q   <= w_ren_d;
            r_wen_q   <= w_wen_d;
        end
    end

    //--------------------------------------------------------------------------
    // Storage: cleared by reset; one commit per ACCESS cycle with ramWEN.
    // ramstore is taken at the commit edge, not when the request latched.
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem_q[i] <= 32'h0;
            end
        end else if (w_access && ramWEN) begin
            r_mem_q[w_lat_idx] <= ramstore;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    always_comb begin
        ramstate = c_FREE;
        case (r_state_q)
            S_IDLE:  ramstate = c_FREE;
            S_WAIT:  ramstate = c_BUSY;
            S_DONE:  ramstate = w_match ? c_ACCESS : c_BUSY;
            S_ERR:   ramstate = c_ERROR;
            default: ramstate = c_FREE;
        endcase
    end

    assign ramload = (w_access && ramREN) ? r_mem_q[w_lat_idx] : 32'h0;

endmodule

`default_nettype wire

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  LAT, 2, number of BUSY cycles before ACCESS; legal range 0..15.
  DEPTH_W, 8, log2 of storage depth in 32-bit words.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  CLK  in  1  the single clock; all state updates on the rising edge.
  nRST  in  1  reset, asynchronous, active-low.
  ramaddr  in  32 (word_t)  byte address of the request.
  ramREN  in  1  read request.
  ramWEN  in  1  write request.
  ramstore  in  32 (word_t)  write data.
  ramload  out  32 (word_t)  read data.
  ramstate  out  ramstate_t  FREE/BUSY/ACCESS/ERROR.
REQ-003 Storage SHALL be 2**DEPTH_W words.
REQ-004 Word index SHALL be ramaddr[DEPTH_W+1:2]; bits above DEPTH_W+1 SHALL be ignored, so addresses alias.

Function
REQ-005 A request SHALL be the tuple {ramaddr, ramREN, ramWEN}; it is valid when exactly one of ramREN/ramWEN is high and ramaddr[1:0]==0.
REQ-006 The FSM SHALL have states IDLE, WAIT, DONE, ERR; the registers SHALL be the state, a 4-bit down-counter, and the latched request.
REQ-007 In IDLE or DONE with a valid request, the FSM SHALL latch it; it SHALL go to DONE if LAT==0, else to WAIT with counter=LAT-1.
REQ-008 In WAIT with the live request equal to the latched request, the counter SHALL decrement each cycle; at counter==0 the FSM SHALL go to DONE.
REQ-009 In WAIT or DONE with a live valid request that differs from the latched one, the FSM SHALL abort and restart per REQ-007 with the new request; no write SHALL occur.
REQ-010 In any state with no request (ramREN==ramWEN==0), the FSM SHALL go to IDLE next cycle.
REQ-011 With ramREN&ramWEN==1 or a misaligned address, the FSM SHALL go to ERR and stay there while that condition holds; when it clears, it SHALL behave as from IDLE.
REQ-012 DONE SHALL last one cycle. With the same request still held, the next cycle SHALL re-latch and start a fresh access per REQ-007, giving back-to-back accesses with no FREE gap.
REQ-013 Latency: a request first presented in cycle 0 SHALL see ramstate==ACCESS in cycle LAT+1, provided it is held stable throughout.
REQ-014 ramstate SHALL be:
  ACCESS when state==DONE and the live request equals the latched request;
  BUSY when state==WAIT, or state==DONE with a mismatching request;
  ERROR when state==ERR;
  FREE when state==IDLE.
REQ-015 ramload SHALL equal mem[latched index] when ramstate==ACCESS and ramREN==1; otherwise it SHALL be 32'h0.
REQ-016 A write SHALL commit ramstore to mem[latched index] at the rising edge ending a cycle with ramstate==ACCESS and ramWEN==1.
REQ-017 Exactly one write SHALL commit per ACCESS cycle.
REQ-018 ramstore SHALL be sampled only at the commit edge, not at latch time.
REQ-019 Read data SHALL reflect all earlier committed writes.

Reset
REQ-020 While nRST==0, asynchronously: state=IDLE, counter=0, latched request=0, all memory words=0.
REQ-021 As a result, while nRST==0 ramstate SHALL be FREE when ramREN==ramWEN==0, and ramload SHALL be 0.
REQ-022 Reset asserted mid-access SHALL discard the access; no partial write SHALL commit.
REQ-023 After deassertion, the first sampled request SHALL be treated as new per REQ-007.

Verification (LAT=2, DEPTH_W=8)
REQ-024 Write then read: hold ramWEN=1, ramaddr=0x10, ramstore=0xDEADBEEF -> BUSY in cycles 1-2, ACCESS in cycle 3, then drop the request. Then hold ramREN=1 at 0x10 -> ACCESS in cycle 3 with ramload=0xDEADBEEF.
REQ-025 Abort: ramREN=1 at 0x20 for 1 cycle, then switch to 0x24 -> BUSY continues; ACCESS occurs 3 cycles after the switch; ramload=mem[9].
REQ-026 Error: ramREN=ramWEN=1 -> ERROR next cycle and held; clear to ramREN only -> ACCESS 3 cycles later. Misaligned address 0x22 -> ERROR.
REQ-027 Reset: assert nRST=0 during cycle 2 of a write to 0x40 -> ramstate=FREE immediately; a later read of 0x40 returns 0x0.
REQ-028 Back-to-back: hold ramREN=1 at 0x0 for 12 cycles -> ACCESS in cycles 3, 6, 9, 12; BUSY otherwise; never FREE.
REQ-029 LAT=0 and aliasing: with LAT=0, a request gives ACCESS in cycle 1. With LAT=2, write 0x5 at 0x404 then read 0x004 -> 0x5.
